data_sync_tx: RTL

- Source-domain launcher for the multi-bit bus synchronizer (`data_synchronizer`).
- Takes words from an upstream valid/ready stream and registers them onto `unsync_bus`.
- Asserts `bus_enable` for a fixed number of source cycles while the bus is held stable.
- Holds the bus for a guard interval afterwards, so the destination samples a stable word before the next launch.

---
 rtl/data_sync_tx.sv | 107 ++++++++++
 1 files changed

// File: rtl/data_sync_tx.sv
// Source-side launcher for the multi-bit bus synchronizer: registers a word onto
// unsync_bus, qualifies it with bus_enable, then guards it. Option: DATA_SYNC_TX_ACK_EN.
module data_sync_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int EN_CYCLES   = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] unsync_bus,
  output logic                  bus_enable,
  output logic                  busy
`ifdef DATA_SYNC_TX_ACK_EN
  ,
  input  logic                  bus_ack
`endif
);

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;

  localparam logic [7:0] EN_LOAD   = 8'(EN_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       ack_ok;
  logic       hold_skip;

`ifdef DATA_SYNC_TX_ACK_EN
  logic ack_meta, ack_s, ack_hi, ack_done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= bus_ack;
      ack_s    <= ack_meta;
    end
  end

  // Sticky pulse tracker: high seen, then low seen. Armed only outside IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_hi   <= 1'b0;
      ack_done <= 1'b0;
    end else if (state == IDLE) begin
      ack_hi   <= 1'b0;
      ack_done <= 1'b0;
    end else begin
      if (ack_s)           ack_hi   <= 1'b1;
      if (ack_hi && !ack_s) ack_done <= 1'b1;
    end
  end

  assign ack_ok    = ack_done;
  assign hold_skip = 1'b0;
`else
  assign ack_ok    = 1'b1;
  assign hold_skip = (HOLD_CYCLES == 0);
`endif

  assign in_ready = RST && (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            unsync_bus <= in_data;
            bus_enable <= 1'b1;
            cnt        <= EN_LOAD;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            bus_enable <= 1'b0;
            if (hold_skip) begin
              state <= IDLE;
            end else begin
              cnt   <= HOLD_LOAD;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt != 8'd0)  cnt   <= cnt - 8'd1;
          else if (ack_ok)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
